rst_sequencer: RTL
==================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent active-low reset channels, legal range 1..16.
REQ-002 Parameter HOLD_CYCLES, default 100: cycles all channels stay asserted after the lock is qualified, minimum 1.
REQ-003 Parameter STAGGER, default 8: cycles between successive channel releases, minimum 1.
REQ-004 Parameter FILT_LEN, default 16: consecutive synchronised-high LOCKED cycles needed to qualify the lock, minimum 1.
REQ-005 CLK  input  1  single clock for all logic.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 LOCKED  input  1  PLL/MMCM lock, asynchronous to CLK.
REQ-008 SOFT_RST  input  1  synchronous active-high re-sequence request.
REQ-009 RST_X_O  output  NUM_CH  per-channel active-low reset, bit k = channel k.
REQ-010 READY  output  1  high only while the sequencer is in RUN.
REQ-011 LOSS_CNT  output  8  saturating count of lock losses detected in RUN.

Function
REQ-012 LOCKED SHALL pass through a 2-flop synchroniser (lk_s) before any use.
REQ-013 The filter counter SHALL clear when lk_s=0 and otherwise increment, saturating at FILT_LEN; lk_ok = (filter==FILT_LEN).
REQ-014 The FSM SHALL have exactly four states: HOLD, COUNT, RELEASE, RUN.
REQ-015 HOLD: all RST_X_O=0 and READY=0; when lk_ok=1 and SOFT_RST=0, move to COUNT with cnt=0.
REQ-016 COUNT: cnt increments each cycle; on the edge where cnt==HOLD_CYCLES-1, move to RELEASE with idx=0 and cnt=0.
REQ-017 RELEASE, per edge: if cnt==0, set RST_X_O[idx]=1.
REQ-018 RELEASE, same edge: if cnt==STAGGER-1, move to RUN when idx==NUM_CH-1, else increment idx and set cnt=0; otherwise increment cnt.
REQ-019 With STAGGER=1, the release of the final channel and the entry to RUN SHALL occur on the same edge.
REQ-020 Channel k SHALL deassert exactly k*STAGGER cycles after channel 0, with channels released in ascending index order.
REQ-021 A released channel SHALL stay high until an abort or RST.
REQ-022 READY SHALL be registered: it goes to 1 on the edge entering RUN and to 0 on the edge leaving RUN.
REQ-023 Abort: in COUNT, RELEASE or RUN, lk_s=0 or SOFT_RST=1 SHALL, on the next edge, force all RST_X_O=0, READY=0, state=HOLD, cnt=0 and idx=0.
REQ-024 SOFT_RST SHALL NOT clear the filter, so with LOCKED stable the sequencer re-enters COUNT on the first edge after SOFT_RST falls.
REQ-025 lk_s=0 SHALL clear the filter, so re-qualification takes FILT_LEN cycles.
REQ-026 SOFT_RST held high SHALL keep the sequencer in HOLD indefinitely.
REQ-027 LOCKED glitches shorter than FILT_LEN cycles (after synchronisation) while in HOLD SHALL only restart the filter.
REQ-028 LOSS_CNT SHALL increment by 1 on each abort from RUN caused by lk_s=0, saturating at 255.
REQ-029 An abort from RUN caused by SOFT_RST alone SHALL NOT change LOSS_CNT.
REQ-030 If lk_s=0 and SOFT_RST=1 occur together in RUN, LOSS_CNT SHALL increment once.
REQ-031 No output SHALL depend combinationally on any input.

Reset
REQ-032 RST=1 SHALL immediately, without waiting for a clock, set: RST_X_O=0, READY=0, LOSS_CNT=0, state=HOLD, synchroniser flops=0, filter=0, cnt=0, idx=0.
REQ-033 RST asserted mid-RELEASE or mid-RUN SHALL give the same result as REQ-032.
REQ-034 After RST falls, behaviour SHALL start from HOLD, with no output change before lk_ok=1.

Verification
REQ-035 Nominal (NUM_CH=3, HOLD_CYCLES=4, STAGGER=2, FILT_LEN=3), LOCKED rises before edge 1 -> RST_X_O[0] rises at edge 11, [1] at edge 13, [2] at edge 15, READY=1 after edge 16.
REQ-036 Same config, LOCKED pulses high for 2 cycles then low -> RST_X_O stays 0, READY stays 0, LOSS_CNT=0.
REQ-037 In RUN, LOCKED drops -> on the edge after lk_s falls, RST_X_O=3'b000, READY=0, LOSS_CNT=1; LOCKED re-rises -> full sequence repeats with the REQ-035 timing.
REQ-038 In RUN, SOFT_RST=1 for 1 cycle -> all channels asserted next edge, LOSS_CNT unchanged, COUNT entered on the following edge, READY returns 4+3*2=10 edges later.
REQ-039 STAGGER=1, NUM_CH=1 -> channel release and READY occur on the same edge; RST mid-RELEASE -> outputs are reset values asynchronously, before the next edge.
REQ-040 257 lock losses from RUN -> LOSS_CNT=255, with no wrap.

Source files
------------

// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//
// Purpose:
//   Power-up / recovery reset sequencer for NUM_CH active-low reset channels.
//   The lock input of a PLL/MMCM is synchronised and debounced. Once the lock
//   is qualified, all channels are held for HOLD_CYCLES cycles. They are then
//   released one at a time in ascending index order, STAGGER cycles apart.
//   After the last release the sequencer reports READY. Losing lock, or a
//   soft reset request, drops every channel back into reset and restarts the
//   sequence. Lock losses seen while running are counted in a saturating
//   8-bit counter.
//
// Ports:
//   clk       in   single clock for all logic
//   rst       in   asynchronous active-high reset
//   locked    in   PLL/MMCM lock, asynchronous to clk
//   soft_rst  in   synchronous active-high re-sequence request
//   rst_x_o   out  [NUM_CH-1:0] per-channel active-low resets (bit k = ch k)
//   ready     out  high only while every channel is released (RUN state)
//   loss_cnt  out  [7:0] saturating count of lock losses detected in RUN
//
// All outputs come straight from flops; none depends combinationally on an
// input.
// -----------------------------------------------------------------------------
module rst_sequencer #(
    parameter int NUM_CH      = 4,    // 1..16
    parameter int HOLD_CYCLES = 100,  // >= 1
    parameter int STAGGER     = 8,    // >= 1
    parameter int FILT_LEN    = 16    // >= 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    input  logic              soft_rst,
    output logic [NUM_CH-1:0] rst_x_o,
    output logic              ready,
    output logic [7:0]        loss_cnt
);

    // -------------------------------------------------------------------------
    // Widths and constants
    // -------------------------------------------------------------------------
    // One shared counter times both the hold phase and the stagger gaps, so it
    // is sized for whichever terminal value is larger.
    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? (HOLD_CYCLES - 1) : (STAGGER - 1);
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_CH < 2) ? 1 : $clog2(NUM_CH);
    localparam int FILT_W  = $clog2(FILT_LEN + 1);

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);
    localparam logic [FILT_W-1:0] FILT_FULL = FILT_W'(FILT_LEN);
    localparam logic [7:0]        LOSS_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_COUNT   = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers and their next-state values
    // -------------------------------------------------------------------------
    logic              sync_meta_reg;
    logic              lk_s_reg;
    logic [FILT_W-1:0] filt_reg;
    logic [FILT_W-1:0] filt_next;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  idx_next;

    logic [NUM_CH-1:0] rst_x_reg;
    logic [NUM_CH-1:0] rst_x_next;
    logic              ready_reg;
    logic              ready_next;
    logic [7:0]        loss_reg;
    logic [7:0]        loss_next;

    logic              lk_ok;
    logic              abort;
    logic              lock_lost;
    logic [NUM_CH-1:0] chan_hit;

    // -------------------------------------------------------------------------
    // Lock synchroniser: two flops, nothing downstream sees the raw input.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_reg <= 1'b0;
            lk_s_reg      <= 1'b0;
        end else begin
            sync_meta_reg <= locked;
            lk_s_reg      <= sync_meta_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Lock filter: counts consecutive synchronised-high cycles, saturating at
    // FILT_LEN. Any low cycle restarts qualification from zero. A soft reset
    // deliberately leaves the filter alone so a re-sequence does not have to
    // re-qualify a lock that never went away.
    // -------------------------------------------------------------------------
    always_comb begin
        filt_next = filt_reg;
        if (!lk_s_reg) begin
            filt_next = '0;
        end else if (filt_reg != FILT_FULL) begin
            filt_next = filt_reg + FILT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_reg <= '0;
        end else begin
            filt_reg <= filt_next;
        end
    end

    assign lk_ok = (filt_reg == FILT_FULL);

    // Abort applies in every state except HOLD; losing lock takes priority
    // over any progress the sequence would otherwise make on this edge.
    assign abort     = (state_reg != S_HOLD) && (!lk_s_reg || soft_rst);
    assign lock_lost = (state_reg == S_RUN) && !lk_s_reg;

    // -------------------------------------------------------------------------
    // FSM process 1: state register (with cnt/idx and registered outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_HOLD;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            rst_x_reg <= '0;
            ready_reg <= 1'b0;
            loss_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            rst_x_reg <= rst_x_next;
            ready_reg <= ready_next;
            loss_reg  <= loss_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;

        if (abort) begin
            state_next = S_HOLD;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                S_HOLD: begin
                    if (lk_ok && !soft_rst) begin
                        state_next = S_COUNT;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end
                end

                S_COUNT: begin
                    // HOLD_CYCLES edges are spent here (cnt 0..HOLD_CYCLES-1).
                    if (cnt_reg == HOLD_LAST) begin
                        state_next = S_RELEASE;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end

                S_RELEASE: begin
                    // The release of channel idx happens at cnt==0 (output
                    // process); the gap to the next channel ends at STAG_LAST.
                    // With STAGGER=1 both conditions hold on the same edge.
                    if (cnt_reg == STAG_LAST) begin
                        cnt_next = '0;
                        if (idx_reg == IDX_LAST) begin
                            state_next = S_RUN;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end

                S_RUN: begin
                    // Stays here until an abort.
                end

                default: begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: output logic (next values of the registered outputs)
    // -------------------------------------------------------------------------
    // One-hot select of the channel released on this edge.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan_hit
            assign chan_hit[gi] = (state_reg == S_RELEASE) &&
                                  (cnt_reg == '0) &&
                                  (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        rst_x_next = rst_x_reg;
        ready_next = 1'b0;
        loss_next  = loss_reg;

        // Released channels are sticky; only HOLD or an abort re-asserts them.
        if (abort || (state_reg == S_HOLD)) begin
            rst_x_next = '0;
        end else begin
            rst_x_next = rst_x_reg | chan_hit;
        end

        // READY mirrors the state being entered, so it rises on the edge that
        // enters RUN and falls on the edge that leaves it.
        ready_next = (state_next == S_RUN);

        // A loss is counted once per abort from RUN with the lock low,
        // whether or not a soft reset arrived on the same edge.
        if (lock_lost && (loss_reg != LOSS_MAX)) begin
            loss_next = loss_reg + 8'd1;
        end
    end

    assign rst_x_o  = rst_x_reg;
    assign ready    = ready_reg;
    assign loss_cnt = loss_reg;

endmodule
